// File: rtl/dmx_1x3_buf.sv
// Buffered 1-to-3 demultiplexer: one valid/ready input routed by in_sel into three
// independent per-channel FIFOs; in_sel=2'b11 words are accepted, discarded and counted.
module dmx_1x3_buf #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_sel,
   output logic             o0_valid,
   input  logic             o0_ready,
   output logic [WIDTH-1:0] o0_data,
   output logic             o1_valid,
   input  logic             o1_ready,
   output logic [WIDTH-1:0] o1_data,
   output logic             o2_valid,
   input  logic             o2_ready,
   output logic [WIDTH-1:0] o2_data,
   output logic             drop_pulse,
   output logic [CNT_W-1:0] drop_cnt
);

   localparam int NCH   = 3;
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OCC_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q    [NCH][DEPTH];
   logic [WIDTH-1:0] mem_d    [NCH][DEPTH];
   logic [PTR_W-1:0] wr_ptr_q [NCH];
   logic [PTR_W-1:0] wr_ptr_d [NCH];
   logic [PTR_W-1:0] rd_ptr_q [NCH];
   logic [PTR_W-1:0] rd_ptr_d [NCH];
   logic [OCC_W-1:0] occ_q    [NCH];
   logic [OCC_W-1:0] occ_d    [NCH];
   logic             drop_pulse_q, drop_pulse_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   logic [NCH-1:0]   ch_full;
   logic [NCH-1:0]   ch_valid;
   logic [NCH-1:0]   ch_ready;
   logic [NCH-1:0]   ch_push;
   logic [NCH-1:0]   ch_pop;
   logic             accept;
   logic             drop;
   logic [WIDTH-1:0] ch_data [NCH];

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign ch_ready = {o2_ready, o1_ready, o0_ready};

   always_comb begin
      for (int k = 0; k < NCH; k++) begin
         ch_full[k]  = (occ_q[k] == OCC_W'(DEPTH));
         ch_valid[k] = (occ_q[k] != '0);
         ch_data[k]  = ch_valid[k] ? mem_q[k][rd_ptr_q[k]] : '0;
      end
   end

   // Ready looks only at the selected channel's occupancy, never at the consumer side.
   always_comb begin
      in_ready = 1'b1;
      case (in_sel)
         2'b00:   in_ready = !ch_full[0];
         2'b01:   in_ready = !ch_full[1];
         2'b10:   in_ready = !ch_full[2];
         default: in_ready = 1'b1;
      endcase
   end

   assign accept = in_valid && in_ready;
   assign drop   = accept && (in_sel == 2'b11);

   always_comb begin
      for (int k = 0; k < NCH; k++) begin
         ch_push[k] = accept && (in_sel == 2'(k));
         ch_pop[k]  = ch_valid[k] && ch_ready[k];
      end
   end

   always_comb begin
      mem_d        = mem_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      occ_d        = occ_q;
      drop_pulse_d = drop;
      drop_cnt_d   = drop ? sat_inc(drop_cnt_q) : drop_cnt_q;
      for (int k = 0; k < NCH; k++) begin
         if (ch_push[k]) begin
            mem_d[k][wr_ptr_q[k]] = in_data;
            wr_ptr_d[k]           = wr_ptr_q[k] + 1'b1;
         end
         if (ch_pop[k]) begin
            rd_ptr_d[k] = rd_ptr_q[k] + 1'b1;
         end
         // Simultaneous push and pop leaves the occupancy unchanged.
         case ({ch_push[k], ch_pop[k]})
            2'b10:   occ_d[k] = occ_q[k] + 1'b1;
            2'b01:   occ_d[k] = occ_q[k] - 1'b1;
            default: occ_d[k] = occ_q[k];
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NCH; k++) begin
            wr_ptr_q[k] <= '0;
            rd_ptr_q[k] <= '0;
            occ_q[k]    <= '0;
         end
         drop_pulse_q <= 1'b0;
         drop_cnt_q   <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         occ_q        <= occ_d;
         drop_pulse_q <= drop_pulse_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   // Storage is not reset; outputs are gated by occupancy so stale words never show.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign o0_valid   = ch_valid[0];
   assign o1_valid   = ch_valid[1];
   assign o2_valid   = ch_valid[2];
   assign o0_data    = ch_data[0];
   assign o1_data    = ch_data[1];
   assign o2_data    = ch_data[2];
   assign drop_pulse = drop_pulse_q;
   assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_dmx_1x3_buf.sv
// Self-checking bench for dmx_1x3_buf: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_dmx_1x3_buf;

   localparam int W  = 32;
   localparam int D  = 2;
   localparam int CW = 8;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic [1:0]    in_sel;
   logic          o0_valid, o1_valid, o2_valid;
   logic          o0_ready, o1_ready, o2_ready;
   logic [W-1:0]  o0_data, o1_data, o2_data;
   logic          drop_pulse;
   logic [CW-1:0] drop_cnt;

   logic [W-1:0] q0[$];
   logic [W-1:0] q1[$];
   logic [W-1:0] q2[$];
   int           exp_cnt;
   logic         exp_pulse;
   int           n_cmp;
   int           n_fail;

   dmx_1x3_buf #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
      .o0_valid(o0_valid), .o0_ready(o0_ready), .o0_data(o0_data),
      .o1_valid(o1_valid), .o1_ready(o1_ready), .o1_data(o1_data),
      .o2_valid(o2_valid), .o2_ready(o2_ready), .o2_data(o2_data),
      .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int qsize(input int k);
      case (k)
         0: return q0.size();
         1: return q1.size();
         2: return q2.size();
         default: return 0;
      endcase
   endfunction

   function automatic logic [W-1:0] qhead(input int k);
      if (qsize(k) == 0) return '0;
      case (k)
         0: return q0[0];
         1: return q1[0];
         default: return q2[0];
      endcase
   endfunction

   function automatic logic dut_v(input int k);
      return (k == 0) ? o0_valid : (k == 1) ? o1_valid : o2_valid;
   endfunction

   function automatic logic [W-1:0] dut_d(input int k);
      return (k == 0) ? o0_data : (k == 1) ? o1_data : o2_data;
   endfunction

   // Reference behaviour at a rising edge: acceptance judged on pre-edge occupancy.
   task automatic model_edge();
      bit acc;
      acc = in_valid && ((in_sel == 2'b11) || (qsize(int'(in_sel)) < D));
      if (o0_ready && q0.size() > 0) void'(q0.pop_front());
      if (o1_ready && q1.size() > 0) void'(q1.pop_front());
      if (o2_ready && q2.size() > 0) void'(q2.pop_front());
      exp_pulse = acc && (in_sel == 2'b11);
      if (exp_pulse && exp_cnt < 255) exp_cnt++;
      if (acc) begin
         case (in_sel)
            2'b00: q0.push_back(in_data);
            2'b01: q1.push_back(in_data);
            2'b10: q2.push_back(in_data);
            default: ;
         endcase
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] s, input logic [W-1:0] d,
                        input logic r0, input logic r1, input logic r2);
      in_valid = v; in_sel = s; in_data = d;
      o0_ready = r0; o1_ready = r1; o2_ready = r2;
   endtask

   task automatic test_reset();
      drive(0, 2'b00, '0, 0, 0, 0);
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      #1;
      n_cmp++;
      if ({o0_valid, o1_valid, o2_valid} !== 3'b000) begin
         n_fail++; $display("FAIL reset_valid: got %b want 000", {o0_valid, o1_valid, o2_valid});
      end
      n_cmp++;
      if (o0_data !== '0 || o1_data !== '0 || o2_data !== '0) begin
         n_fail++; $display("FAIL reset_data: got %h %h %h want 0", o0_data, o1_data, o2_data);
      end
      n_cmp++;
      if (drop_pulse !== 1'b0 || drop_cnt !== '0) begin
         n_fail++; $display("FAIL reset_drop: got pulse=%b cnt=%0d want 0/0", drop_pulse, drop_cnt);
      end
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_single();
      drive(1, 2'b00, 32'h0000_00AA, 1, 1, 1);
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL single_ready: got %b want 1", in_ready);
      end
      tick();
      drive(0, 2'b00, '0, 1, 1, 1);
      #1;
      n_cmp++;
      if (o0_valid !== 1'b1 || o0_data !== 32'hAA || o1_valid !== 1'b0 || o2_valid !== 1'b0) begin
         n_fail++; $display("FAIL single_out: got v=%b%b%b d=%h want v=001 d=000000aa",
                            o2_valid, o1_valid, o0_valid, o0_data);
      end
      tick();
      n_cmp++;
      if ({o2_valid, o1_valid, o0_valid} !== 3'b000) begin
         n_fail++; $display("FAIL single_drain: got %b want 000", {o2_valid, o1_valid, o0_valid});
      end
   endtask

   task automatic test_backpressure();
      drive(1, 2'b01, 32'h11, 0, 0, 0);
      tick();
      drive(1, 2'b01, 32'h22, 0, 0, 0);
      tick();
      drive(1, 2'b01, 32'h33, 0, 0, 0);
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL bp_full_ready: got %b want 0", in_ready);
      end
      tick();
      drive(0, 2'b01, '0, 0, 1, 0);
      #1;
      n_cmp++;
      if (o1_valid !== 1'b1 || o1_data !== 32'h11) begin
         n_fail++; $display("FAIL bp_head0: got v=%b d=%h want 1/00000011", o1_valid, o1_data);
      end
      tick();
      n_cmp++;
      if (o1_valid !== 1'b1 || o1_data !== 32'h22) begin
         n_fail++; $display("FAIL bp_head1: got v=%b d=%h want 1/00000022", o1_valid, o1_data);
      end
      tick();
      n_cmp++;
      if (o1_valid !== 1'b0) begin
         n_fail++; $display("FAIL bp_empty: got %b want 0", o1_valid);
      end
      drive(1, 2'b01, 32'h33, 0, 0, 0);
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL bp_reaccept_ready: got %b want 1", in_ready);
      end
      tick();
      drive(0, 2'b01, '0, 0, 1, 0);
      #1;
      n_cmp++;
      if (o1_valid !== 1'b1 || o1_data !== 32'h33) begin
         n_fail++; $display("FAIL bp_reaccept: got v=%b d=%h want 1/00000033", o1_valid, o1_data);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      drive(1, 2'b00, 32'hA0, 1, 1, 1);
      tick();
      drive(1, 2'b10, 32'hB0, 1, 1, 1);
      #1;
      n_cmp++;
      if (o0_valid !== 1'b1 || o0_data !== 32'hA0 || o2_valid !== 1'b0) begin
         n_fail++; $display("FAIL b2b_a0: got v0=%b d0=%h v2=%b want 1/a0/0", o0_valid, o0_data, o2_valid);
      end
      tick();
      drive(1, 2'b00, 32'hA1, 1, 1, 1);
      #1;
      n_cmp++;
      if (o2_valid !== 1'b1 || o2_data !== 32'hB0 || o0_valid !== 1'b0) begin
         n_fail++; $display("FAIL b2b_b0: got v2=%b d2=%h v0=%b want 1/b0/0", o2_valid, o2_data, o0_valid);
      end
      tick();
      drive(0, 2'b00, '0, 1, 1, 1);
      #1;
      n_cmp++;
      if (o0_valid !== 1'b1 || o0_data !== 32'hA1 || o2_valid !== 1'b0) begin
         n_fail++; $display("FAIL b2b_a1: got v0=%b d0=%h v2=%b want 1/a1/0", o0_valid, o0_data, o2_valid);
      end
      tick();
   endtask

   task automatic test_full_pop_push();
      drive(1, 2'b10, 32'hC0, 1, 1, 0);
      tick();
      drive(1, 2'b10, 32'hC1, 1, 1, 0);
      tick();
      drive(1, 2'b10, 32'hC2, 1, 1, 1);
      #1;
      n_cmp++;
      if (in_ready !== 1'b0 || o2_data !== 32'hC0) begin
         n_fail++; $display("FAIL full_refuse: got rdy=%b d2=%h want 0/c0", in_ready, o2_data);
      end
      tick();
      n_cmp++;
      if (in_ready !== 1'b1 || o2_valid !== 1'b1 || o2_data !== 32'hC1) begin
         n_fail++; $display("FAIL full_after_pop: got rdy=%b v2=%b d2=%h want 1/1/c1", in_ready, o2_valid, o2_data);
      end
      tick();
      drive(0, 2'b10, '0, 1, 1, 1);
      #1;
      n_cmp++;
      if (o2_valid !== 1'b1 || o2_data !== 32'hC2) begin
         n_fail++; $display("FAIL full_late_push: got v2=%b d2=%h want 1/c2", o2_valid, o2_data);
      end
      tick();
   endtask

   task automatic test_random();
      bit stall;
      int r;
      logic exp_rdy;
      stall = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (!stall) begin
            r = int'($urandom_range(0, 15));
            in_valid = ($urandom_range(0, 3) != 0);
            in_sel   = (r == 0) ? 2'b11 : 2'(r % 3);
            in_data  = $urandom;
         end
         o0_ready = ($urandom_range(0, 2) != 0);
         o1_ready = ($urandom_range(0, 1) != 0);
         o2_ready = ($urandom_range(0, 3) == 0);
         #1;
         for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (dut_v(k) !== (qsize(k) > 0) || dut_d(k) !== qhead(k)) begin
               n_fail++; $display("FAIL rand_ch%0d cyc %0d: got v=%b d=%h want v=%b d=%h",
                                  k, i, dut_v(k), dut_d(k), qsize(k) > 0, qhead(k));
            end
         end
         exp_rdy = (in_sel == 2'b11) || (qsize(int'(in_sel)) < D);
         n_cmp++;
         if (in_ready !== exp_rdy) begin
            n_fail++; $display("FAIL rand_in_ready cyc %0d: got %b want %b", i, in_ready, exp_rdy);
         end
         n_cmp++;
         if (drop_pulse !== exp_pulse || drop_cnt !== CW'(exp_cnt)) begin
            n_fail++; $display("FAIL rand_drop cyc %0d: got %b/%0d want %b/%0d",
                               i, drop_pulse, drop_cnt, exp_pulse, exp_cnt);
         end
         stall = in_valid && !in_ready;
         tick();
      end
      drive(0, 2'b00, '0, 1, 1, 1);
      repeat (3) tick();
   endtask

   task automatic test_drop_saturate();
      int want;
      drive(1, 2'b11, 32'hDEAD_BEEF, 1, 1, 1);
      for (int i = 0; i < 260; i++) begin
         tick();
         want = exp_cnt;
         n_cmp++;
         if (drop_pulse !== 1'b1 || drop_cnt !== CW'(want) || in_ready !== 1'b1 ||
             {o0_valid, o1_valid, o2_valid} !== 3'b000) begin
            n_fail++; $display("FAIL drop_%0d: got pulse=%b cnt=%0d rdy=%b v=%b%b%b want 1/%0d/1/000",
                               i, drop_pulse, drop_cnt, in_ready, o2_valid, o1_valid, o0_valid, want);
         end
      end
      n_cmp++;
      if (drop_cnt !== 8'd255) begin
         n_fail++; $display("FAIL drop_saturated: got %0d want 255", drop_cnt);
      end
      drive(0, 2'b00, '0, 1, 1, 1);
      tick();
      n_cmp++;
      if (drop_pulse !== 1'b0 || drop_cnt !== 8'd255) begin
         n_fail++; $display("FAIL drop_idle: got pulse=%b cnt=%0d want 0/255", drop_pulse, drop_cnt);
      end
   endtask

   task automatic test_async_reset();
      drive(1, 2'b00, 32'h5, 0, 0, 0);
      tick();
      tick();
      drive(0, 2'b00, '0, 0, 0, 0);
      #1;
      n_cmp++;
      if (o0_valid !== 1'b1 || o0_data !== 32'h5) begin
         n_fail++; $display("FAIL areset_fill: got v=%b d=%h want 1/5", o0_valid, o0_data);
      end
      #2 rst_n = 1'b0;
      q0.delete(); q1.delete(); q2.delete();
      exp_cnt = 0; exp_pulse = 1'b0;
      #1;
      n_cmp++;
      if (o0_valid !== 1'b0 || o0_data !== '0 || drop_cnt !== '0 || drop_pulse !== 1'b0) begin
         n_fail++; $display("FAIL areset_now: got v=%b d=%h cnt=%0d pulse=%b want 0/0/0/0",
                            o0_valid, o0_data, drop_cnt, drop_pulse);
      end
      tick();
      #2 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if ({o0_valid, o1_valid, o2_valid} !== 3'b000) begin
            n_fail++; $display("FAIL areset_quiet_%0d: got %b want 000", i, {o0_valid, o1_valid, o2_valid});
         end
      end
      drive(1, 2'b00, 32'h77, 1, 1, 1);
      tick();
      drive(0, 2'b00, '0, 1, 1, 1);
      #1;
      n_cmp++;
      if (o0_valid !== 1'b1 || o0_data !== 32'h77) begin
         n_fail++; $display("FAIL areset_repush: got v=%b d=%h want 1/77", o0_valid, o0_data);
      end
      tick();
   endtask

   initial begin
      n_cmp = 0; n_fail = 0; exp_cnt = 0; exp_pulse = 1'b0;
      test_reset();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_full_pop_push();
      test_random();
      test_drop_saturate();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/dmx_1x3_buf.md
Name: dmx_1x3_buf

Overview:
- Buffered 1-to-3 demultiplexer, the distribution-side counterpart of the 3-input result multiplexer.
- Takes one 32-bit word plus a 2-bit channel select over a valid/ready handshake.
- Routes the word into one of three per-channel FIFOs; each channel drains independently over its own valid/ready handshake.
- Used to steer a single producer (e.g. a load/ALU result path) to three consumers without losing ordering inside a channel.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 2, entries per channel FIFO; power of two, minimum 2.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  WIDTH  word to route.
- in_sel  input  2  destination: 2'b00 ch0, 2'b01 ch1, 2'b10 ch2, 2'b11 invalid.
- o0_valid / o1_valid / o2_valid  output  1 each  channel FIFO non-empty.
- o0_ready / o1_ready / o2_ready  input  1 each  consumer takes head word.
- o0_data / o1_data / o2_data  output  WIDTH each  channel FIFO head word.
- drop_pulse  output  1  one-cycle pulse when a word with in_sel=2'b11 is accepted.
- drop_cnt  output  CNT_W  saturating count of dropped words.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All FIFOs empty; read/write pointers 0.
  - All oN_valid=0, oN_data=0, drop_pulse=0, drop_cnt=0.
  - Reset asserted mid-transfer discards all buffered words; nothing is emitted after release until new pushes arrive.
- Ready and acceptance:
  - in_ready is combinational from in_sel and the occupancy of the selected FIFO only: in_ready = (in_sel==2'b11) ? 1 : !full[in_sel].
  - in_ready does not depend on the same-cycle oN_ready. A full channel refuses a push even if it is popped in the same cycle.
  - Accept occurs when in_valid && in_ready at the clock edge.
- Push (in_sel = 0..2): in_data is written at the write pointer of the selected FIFO; the write pointer increments modulo DEPTH.
- Drop (in_sel = 2'b11):
  - The word is accepted and discarded.
  - drop_pulse=1 in the following cycle.
  - drop_cnt increments and saturates at all-ones with no wrap.
- Latency: a word accepted at edge N shows oN_valid=1 and oN_data=word in the cycle after edge N. There is no combinational bypass from in_data to oN_data.
- Pop: when oN_valid && oN_ready at an edge, the head is removed and the read pointer increments modulo DEPTH.
  - oN_ready while oN_valid=0 has no effect.
- Occupancy:
  - Tracked per channel with a (log2(DEPTH)+1)-bit count: +1 on push, -1 on pop, unchanged on simultaneous push and pop.
  - full = (count==DEPTH); empty = (count==0).
- Simultaneous events:
  - Push to channel k and pop from channel k in one cycle (only possible when not full): both happen; count unchanged; ordering preserved.
  - Pops on all three channels plus a push to any one channel in the same cycle are all honoured.
- Ordering: FIFO order within a channel. No ordering guarantee across channels.
- Protocol requirements:
  - Outputs: oN_data is stable while oN_valid=1 and oN_ready=0.
  - Producer: must hold in_data/in_sel stable while in_valid=1 and in_ready=0. The block does not check this.
- Pointer wrap: the pointers wrap from DEPTH-1 to 0 with no bubble.

Test Plan:
- Reset, then in_valid=1, in_sel=00, in_data=32'h0000_00AA with o0_ready=1 -> in_ready=1; the next cycle o0_valid=1, o0_data=0xAA; the cycle after, o0_valid=0. o1_valid and o2_valid stay 0 throughout.
- With o1_ready=0, push 0x11, 0x22, then 0x33 to ch1 -> first two accepted, then in_ready=0. Raise o1_ready -> 0x11 then 0x22 drain in order. Push 0x33 again -> accepted.
- Push 0xA0 (ch0), 0xB0 (ch2), 0xA1 (ch0) back-to-back with all readies=1 -> o0 emits 0xA0 then 0xA1, o2 emits 0xB0, each one cycle after acceptance.
- ch2 full, o2_ready=1, push to ch2 in the same cycle -> in_ready=0 and the push is refused; the head pops. Next cycle the push is accepted.
- in_sel=11 for 260 consecutive accepts (CNT_W=8) -> drop_pulse high each following cycle; drop_cnt stops at 255; no oN_valid asserts.
- Fill ch0 with 0x5, assert rst_n=0 asynchronously mid-cycle -> o0_valid drops immediately and drop_cnt=0. After release, o0_valid stays 0 until a new push.
